cache_2way_lru: RTL and testbench

Parametrised two-way set-associative, write-back, write-allocate data cache with per-set LRU replacement. It sits between the pipeline's memory stage and the line-wide main-memory model, and succeeds the direct-mapped cache. Set count and line length are configurable. It adds hit and miss counters for benchmarking.

---
 rtl/cache_2way_lru.sv | 199 +++++++++++++++++++
 tb/tb_cache_2way_lru.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_2way_lru.sv
// cache_2way_lru
//
// Two-way set-associative, write-back, write-allocate data cache with a
// single LRU bit per set. It sits between the pipeline memory stage and a
// line-wide main-memory model.
//
// Ports
//   clk, proc_reset       clock; asynchronous active-high reset
//   proc_read/proc_write  processor request (write wins when both are high)
//   proc_addr             word address {tag, index, offset}
//   proc_wdata            write data
//   proc_rdata            read data of the hitting way, 0 without a hit
//   proc_stall            processor must hold its request while high
//   mem_read/mem_write    registered line fetch / write-back request
//   mem_addr              registered line address {tag, index}
//   mem_wdata             registered victim line, word 0 in the LSBs
//   mem_rdata             fetched line, word 0 in the LSBs
//   mem_ready             memory completes the current request this cycle
//   hit_cnt/miss_cnt      saturating performance counters
//
// Memory handshake: a request (mem_read or mem_write) is raised by the cache
// and held, together with mem_addr/mem_wdata, until the first rising edge at
// which mem_ready is sampled high; that edge completes the transfer, and
// mem_rdata is captured on the same edge for a fetch. mem_ready is ignored
// while no request is pending, and the two requests are never high together.
module cache_2way_lru #(
  parameter int SETS   = 8,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 30,
  parameter int CNT_W  = 16
) (
  input  logic                                  clk,
  input  logic                                  proc_reset,
  input  logic                                  proc_read,
  input  logic                                  proc_write,
  input  logic [ADDR_W-1:0]                     proc_addr,
  input  logic [31:0]                           proc_wdata,
  output logic [31:0]                           proc_rdata,
  output logic                                  proc_stall,
  output logic                                  mem_read,
  output logic                                  mem_write,
  output logic [ADDR_W-$clog2(WORDS)-1:0]       mem_addr,
  output logic [32*WORDS-1:0]                   mem_wdata,
  input  logic [32*WORDS-1:0]                   mem_rdata,
  input  logic                                  mem_ready,
  output logic [CNT_W-1:0]                      hit_cnt,
  output logic [CNT_W-1:0]                      miss_cnt
);

  localparam int INDEX_W  = $clog2(SETS);
  localparam int OFFSET_W = $clog2(WORDS);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W   = 32 * WORDS;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } state_t;

  state_t state;

  // Address fields
  logic [TAG_W-1:0]    proc_tag;
  logic [INDEX_W-1:0]  idx;
  logic [OFFSET_W-1:0] off;
  logic [OFFSET_W+4:0] word_lsb;

  assign proc_tag = proc_addr[ADDR_W-1 -: TAG_W];
  assign idx      = proc_addr[OFFSET_W +: INDEX_W];
  assign off      = proc_addr[OFFSET_W-1:0];
  assign word_lsb = {off, 5'd0};

  // Storage: per-way status bit vectors, tag and line arrays, one LRU bit per
  // set naming the least-recently-used way.
  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   dirty_q [2];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_mem  [2][SETS];
  logic [LINE_W-1:0] line_mem [2][SETS];

  // Combinational lookup
  logic request;
  logic match0;
  logic match1;
  logic hit;
  logic hit_way;

  assign request = proc_read | proc_write;
  assign match0  = valid_q[0][idx] && (tag_mem[0][idx] == proc_tag);
  assign match1  = valid_q[1][idx] && (tag_mem[1][idx] == proc_tag);
  assign hit     = request & (match0 | match1);
  // The two ways never hold the same tag, so match1 alone names the way.
  assign hit_way = match1;

  assign proc_rdata = hit ? line_mem[hit_way][idx][word_lsb +: 32] : 32'd0;
  assign proc_stall = (state != IDLE) | (request & ~hit);

  // Victim choice: fill an empty way before evicting, way 0 first.
  logic victim_way;
  logic victim_dirty;
  logic victim_q;

  always_comb begin
    victim_way = lru_q[idx];
    if (!valid_q[0][idx]) begin
      victim_way = 1'b0;
    end else if (!valid_q[1][idx]) begin
      victim_way = 1'b1;
    end
  end

  assign victim_dirty = valid_q[victim_way][idx] & dirty_q[victim_way][idx];

  // Control FSM, status bits, memory request registers and counters.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state      <= IDLE;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
      victim_q   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            lru_q[idx] <= ~hit_way;
            if (proc_write) begin
              dirty_q[hit_way][idx] <= 1'b1;
            end
            if (hit_cnt != {CNT_W{1'b1}}) begin
              hit_cnt <= hit_cnt + 1'b1;
            end
          end else if (request) begin
            if (miss_cnt != {CNT_W{1'b1}}) begin
              miss_cnt <= miss_cnt + 1'b1;
            end
            victim_q <= victim_way;
            if (victim_dirty) begin
              mem_write <= 1'b1;
              mem_addr  <= {tag_mem[victim_way][idx], idx};
              mem_wdata <= line_mem[victim_way][idx];
              state     <= WRITE_BACK;
            end else begin
              mem_read <= 1'b1;
              mem_addr <= {proc_tag, idx};
              state    <= ALLOCATE;
            end
          end
        end

        WRITE_BACK: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= {proc_tag, idx};
            state     <= ALLOCATE;
          end
        end

        ALLOCATE: begin
          if (mem_ready) begin
            valid_q[victim_q][idx] <= 1'b1;
            dirty_q[victim_q][idx] <= 1'b0;
            lru_q[idx]             <= ~victim_q;
            mem_read               <= 1'b0;
            state                  <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify their contents.
  // While reset is held the state is IDLE and no way is valid, so neither
  // write path can fire.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && hit && proc_write) begin
      line_mem[hit_way][idx][word_lsb +: 32] <= proc_wdata;
    end
    if ((state == ALLOCATE) && mem_ready) begin
      line_mem[victim_q][idx] <= mem_rdata;
      tag_mem[victim_q][idx]  <= proc_tag;
    end
  end

endmodule

// File: tb/tb_cache_2way_lru.sv
// Testbench for cache_2way_lru (SETS=8, WORDS=4, ADDR_W=30, CNT_W=4).
// A behavioural main memory answers line requests after a programmable
// latency; a word-level reference of the processor's view of memory supplies
// the expected read data, queued when a read is issued and compared when the
// cache delivers it.
module tb_cache_2way_lru;

  localparam int SETS   = 8;
  localparam int WORDS  = 4;
  localparam int ADDR_W = 30;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Clock / reset
  logic clk = 1'b0;
  logic proc_reset = 1'b1;
  always #5 clk = ~clk;

  logic              proc_read = 1'b0;
  logic              proc_write = 1'b0;
  logic [29:0]       proc_addr = '0;
  logic [31:0]       proc_wdata = '0;
  logic [31:0]       proc_rdata;
  logic              proc_stall;
  logic              mem_read;
  logic              mem_write;
  logic [27:0]       mem_addr;
  logic [127:0]      mem_wdata;
  logic [127:0]      mem_rdata = '0;
  logic              mem_ready;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  cache_2way_lru #(
    .SETS(SETS), .WORDS(WORDS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .proc_reset(proc_reset),
    .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_rdata(proc_rdata), .proc_stall(proc_stall),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Scoreboard and bookkeeping
  logic [31:0]  exp_q[$];
  logic [27:0]  wb_addr_q[$];
  logic [127:0] wb_data_q[$];
  logic [27:0]  rd_addr_q[$];
  logic [127:0] mem_lines [logic [27:0]];
  logic [31:0]  ref_word  [logic [29:0]];
  int n_checks = 0;
  int n_fail = 0;
  int hit_exp = 0;
  int miss_exp = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Initial memory image: line 0x4 holds {4,3,2,1}, everything else a pattern.
  function automatic logic [31:0] init_word(input logic [29:0] a);
    if (a[29:2] == 28'h4) return 32'(a[1:0]) + 32'd1;
    return {2'b10, a} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] get_line(input logic [27:0] la);
    logic [127:0] l;
    if (mem_lines.exists(la)) return mem_lines[la];
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = init_word({la, 2'(w)});
    return l;
  endfunction

  function automatic logic [31:0] ref_read(input logic [29:0] a);
    if (ref_word.exists(a)) return ref_word[a];
    return init_word(a);
  endfunction

  // Memory responder: completes each request on its mem_lat-th cycle.
  int   mem_lat = 3;
  int   mem_cnt = 0;
  logic rdy = 1'b0;
  logic poke = 1'b0;
  assign mem_ready = rdy | poke;

  always @(negedge clk) begin
    if (!(mem_read || mem_write)) begin
      mem_cnt = 0;
      rdy = 1'b0;
    end else begin
      if (rdy) mem_cnt = 0;
      mem_cnt++;
      rdy = (mem_cnt >= mem_lat);
      if (rdy) begin
        if (mem_write) begin
          mem_lines[mem_addr] = mem_wdata;
          wb_addr_q.push_back(mem_addr);
          wb_data_q.push_back(mem_wdata);
        end else begin
          rd_addr_q.push_back(mem_addr);
          mem_rdata = get_line(mem_addr);
        end
      end
    end
  end

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Driver: one processor access held until the cache stops stalling.
  task automatic do_access(input logic rd, input logic wr, input logic [29:0] addr,
                           input logic [31:0] wd, output int stalls);
    logic [31:0] e;
    @(negedge clk);
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = addr;
    proc_wdata = wd;
    if (wr) ref_word[addr] = wd;
    else exp_q.push_back(ref_read(addr));
    #1;
    stalls = 0;
    while (proc_stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check_eq("stall_released", proc_stall, 1'b0);
    if (!wr) begin
      e = exp_q.pop_front();
      check_eq("rdata", proc_rdata, e);
    end
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    hit_exp = sat_inc(hit_exp);
    if (stalls > 0) miss_exp = sat_inc(miss_exp);
    check_eq("hit_cnt", hit_cnt, hit_exp);
    check_eq("miss_cnt", miss_cnt, miss_exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st;
    int guard;
    logic [127:0] line;
    logic [29:0] a;
    logic rd_sel;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_mem_read", mem_read, 1'b0);
    check_eq("rst_mem_write", mem_write, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 28'd0);
    check_eq("rst_mem_wdata", mem_wdata, 128'd0);
    check_eq("rst_stall", proc_stall, 1'b0);
    check_eq("rst_rdata", proc_rdata, 32'd0);
    check_eq("rst_hit_cnt", hit_cnt, 0);
    check_eq("rst_miss_cnt", miss_cnt, 0);
    proc_reset = 1'b0;

    // Clean miss: 4 stall cycles, then word 0 = 1
    do_access(1'b1, 1'b0, 30'h10, 32'd0, st);
    check_eq("a_stalls", st, 4);
    check_eq("a_fetch_addr", rd_addr_q[0], 28'h4);

    // Second tag in set 4 fills way1 without write-back; both then hit
    do_access(1'b1, 1'b0, 30'h30, 32'd0, st);
    check_eq("b_stalls", st, 4);
    check_eq("b_no_wb", wb_addr_q.size(), 0);
    do_access(1'b1, 1'b0, 30'h10, 32'd0, st);
    check_eq("b_hit0_stalls", st, 0);
    do_access(1'b1, 1'b0, 30'h30, 32'd0, st);
    check_eq("b_hit1_stalls", st, 0);

    // Dirty eviction of way0
    do_access(1'b0, 1'b1, 30'h11, 32'hDEADBEEF, st);
    check_eq("c_wr_stalls", st, 0);
    do_access(1'b1, 1'b0, 30'h30, 32'd0, st);
    check_eq("c_touch_way1", st, 0);
    do_access(1'b1, 1'b0, 30'h50, 32'd0, st);
    check_eq("c_stalls", st, 7);
    check_eq("c_wb_count", wb_addr_q.size(), 1);
    check_eq("c_wb_addr", wb_addr_q[0], 28'h4);
    line = wb_data_q[0];
    check_eq("c_wb_word1", line[63:32], 32'hDEADBEEF);
    check_eq("c_fetch_addr", rd_addr_q[rd_addr_q.size()-1], 28'h14);

    // Read and write together act as a write and dirty the line
    do_access(1'b1, 1'b1, 30'h31, 32'h12345678, st);
    check_eq("d_rw_stalls", st, 0);
    do_access(1'b1, 1'b0, 30'h31, 32'd0, st);
    do_access(1'b1, 1'b0, 30'h50, 32'd0, st);
    check_eq("d_hit_stalls", st, 0);
    do_access(1'b1, 1'b0, 30'h70, 32'd0, st);
    check_eq("d_stalls", st, 7);
    check_eq("d_wb_count", wb_addr_q.size(), 2);
    check_eq("d_wb_addr", wb_addr_q[1], 28'hC);
    line = wb_data_q[1];
    check_eq("d_wb_word1", line[63:32], 32'h12345678);

    // Reset while fetching aborts the miss
    mem_lat = 20;
    @(negedge clk);
    proc_read = 1'b1;
    proc_addr = 30'h90;
    #1;
    guard = 0;
    while (!mem_read && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check_eq("e_alloc_reached", mem_read, 1'b1);
    proc_reset = 1'b1;
    #1;
    check_eq("e_mem_read_drop", mem_read, 1'b0);
    check_eq("e_mem_write", mem_write, 1'b0);
    check_eq("e_mem_addr", mem_addr, 28'd0);
    check_eq("e_stall_miss", proc_stall, 1'b1);
    check_eq("e_hit_cnt", hit_cnt, 0);
    check_eq("e_miss_cnt", miss_cnt, 0);
    proc_read = 1'b0;
    #1;
    check_eq("e_stall_idle", proc_stall, 1'b0);
    @(negedge clk);
    proc_reset = 1'b0;
    mem_lat = 3;
    hit_exp = 0;
    miss_exp = 0;
    do_access(1'b1, 1'b0, 30'h10, 32'd0, st);
    check_eq("e_remiss_stalls", st, 4);
    do_access(1'b1, 1'b0, 30'h11, 32'd0, st);
    check_eq("e_rehit_stalls", st, 0);

    // Random traffic over a few tags in every set
    for (int i = 0; i < 40; i++) begin
      a = 30'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      rd_sel = ($urandom_range(0, 2) != 0);
      mem_lat = $urandom_range(1, 4);
      do_access(rd_sel, ~rd_sel, a, $urandom, st);
    end
    mem_lat = 3;

    // Hit counter saturation
    for (int i = 0; i < 20; i++) begin
      do_access(1'b1, 1'b0, 30'h10 | 30'($urandom_range(0, 3)), 32'd0, st);
    end
    check_eq("f_hit_sat", hit_cnt, 4'd15);

    // mem_ready while idle is ignored
    @(negedge clk);
    poke = 1'b1;
    repeat (2) @(negedge clk);
    poke = 1'b0;
    #1;
    check_eq("g_idle_mem_read", mem_read, 1'b0);
    check_eq("g_idle_mem_write", mem_write, 1'b0);
    check_eq("g_idle_stall", proc_stall, 1'b0);
    do_access(1'b1, 1'b0, 30'h12, 32'd0, st);
    check_eq("g_hit_stalls", st, 0);
    check_eq("g_hit_sat", hit_cnt, 4'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
